// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory master: address width,
// access-size encodings and the controller state enum.
package lsu_pkg;

  localparam int ADDR_W = 11;
  localparam int XLEN   = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_MERGE,
    ST_RESP
  } lsu_state_e;

endpackage

// File: rtl/lsu_mem_master_lane_unit.sv
// Combinational big-endian lane logic: load extract/extend, sub-word store
// merge, and the alignment check applied to incoming requests.
module lsu_lane_unit
  import lsu_pkg::*;
(
  input  logic [1:0]      size,
  input  logic [1:0]      off,
  input  logic            uns,
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] wdata,
  input  logic [1:0]      chk_size,
  input  logic [1:0]      chk_off,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] merge_data,
  output logic            chk_mis
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Byte offset 0 is the most significant lane (big-endian).
  always_comb begin
    byte_lane = rdata[7:0];
    case (off)
      2'd0: byte_lane = rdata[31:24];
      2'd1: byte_lane = rdata[23:16];
      2'd2: byte_lane = rdata[15:8];
      default: byte_lane = rdata[7:0];
    endcase
    half_lane = off[1] ? rdata[15:0] : rdata[31:16];

    load_data = rdata;
    case (size)
      SZ_BYTE: load_data = uns ? {24'b0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      SZ_HALF: load_data = uns ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
      default: load_data = rdata;
    endcase
  end

  always_comb begin
    merge_data = wdata;
    case (size)
      SZ_BYTE: begin
        merge_data = rdata;
        case (off)
          2'd0: merge_data[31:24] = wdata[7:0];
          2'd1: merge_data[23:16] = wdata[7:0];
          2'd2: merge_data[15:8]  = wdata[7:0];
          default: merge_data[7:0] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        merge_data = rdata;
        if (off[1]) merge_data[15:0] = wdata[15:0];
        else        merge_data[31:16] = wdata[15:0];
      end
      default: merge_data = wdata;
    endcase
  end

  assign chk_mis = (chk_size == 2'b11) ||
                   (chk_size == SZ_WORD && chk_off != 2'b00) ||
                   (chk_size == SZ_HALF && chk_off[0]);

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: accepts one CPU request at a time, drives the
// word-addressed RAM (with read-modify-write for sub-word stores) and pulses a response.
module lsu_mem_master
  import lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_misaligned,
  output logic              resp_range_err,
  output logic              resp_fault,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              mem_we,
  input  logic [31:0]       mem_dout,
  input  logic [7:0]        mem_seg_faults
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              we_q, we_d, uns_q, uns_d, mis_q, mis_d, rng_q, rng_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              req_mis, req_rng, err;
  logic [ADDR_W-1:0] waddr;
  logic [XLEN-1:0]   load_data, merge_data;

  assign req_rng = |req_addr[XLEN-1:ADDR_W];
  assign waddr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign err     = mis_q | rng_q;

  lsu_lane_unit u_lane (
    .size       (size_q),
    .off        (addr_q[1:0]),
    .uns        (uns_q),
    .rdata      (mem_dout),
    .wdata      (wdata_q),
    .chk_size   (req_size),
    .chk_off    (req_addr[1:0]),
    .load_data  (load_data),
    .merge_data (merge_data),
    .chk_mis    (req_mis)
  );

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    size_d          = size_q;
    we_d            = we_q;
    uns_d           = uns_q;
    wdata_d         = wdata_q;
    mis_d           = mis_q;
    rng_d           = rng_q;
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    resp_rdata      = '0;
    resp_misaligned = 1'b0;
    resp_range_err  = 1'b0;
    resp_fault      = 1'b0;
    mem_addr        = '0;
    mem_din         = '0;
    mem_we          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr[ADDR_W-1:0];
          size_d  = req_size;
          we_d    = req_we;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          mis_d   = req_mis;
          rng_d   = req_rng;
          if (req_mis || req_rng)                 state_d = ST_RESP;
          else if (req_we && req_size == SZ_WORD) state_d = ST_WR;
          else                                    state_d = ST_RD;
        end
      end
      ST_RD: begin
        mem_addr = waddr;
        state_d  = we_q ? ST_MERGE : ST_RESP;
      end
      ST_MERGE, ST_WR: begin
        mem_addr = waddr;
        mem_din  = merge_data;
        mem_we   = 1'b1;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        resp_valid      = 1'b1;
        resp_misaligned = mis_q;
        resp_range_err  = rng_q;
        if (!err) begin
          resp_fault = mem_seg_faults[addr_q[ADDR_W-1:8]];
          if (!we_q) resp_rdata = load_data;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A reset arriving mid-write must not let the write through.
    if (rst) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= SZ_BYTE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      rng_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
      rng_q   <= rng_d;
    end
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that turns CPU load/store requests (byte/half/word, signed/unsigned) into RAM accesses.
- Drives the 11-bit byte-addressed, big-endian, 8×256-byte RAM.
- Sits between the execute stage and RAM.
- Performs aligned word reads/writes, lane extraction with sign/zero extension, and read-modify-write for sub-word stores.
- Rejects misaligned or out-of-range requests without touching memory.

Parameters:
- ADDR_W, 11, RAM byte-address width; addresses with any bit set at or above ADDR_W are out of range.
- XLEN, 32, CPU data/address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and treated as misaligned
- req_unsigned  in  1  loads only: zero-extend (1) or sign-extend (0)
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, right-justified
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  XLEN  load result; 0 for stores and errors
- resp_misaligned  out  1  half not 2-aligned, word not 4-aligned, or size=11
- resp_range_err  out  1  req_addr[XLEN-1:ADDR_W] != 0
- resp_fault  out  1  RAM seg_fault bit of the addressed chip, sampled in RESP
- mem_addr  out  ADDR_W  RAM byte address, always word-aligned
- mem_din  out  32  RAM write data
- mem_we  out  1  RAM write enable
- mem_dout  in  32  RAM read data, registered, valid the cycle after the address is driven with mem_we=0
- mem_seg_faults  in  8  RAM per-chip fault flags

Behaviour:
- Reset: state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; all error flags 0; mem_addr=0, mem_din=0, mem_we=0.
- Reset mid-operation aborts immediately; no mem_we pulse is issued on or after the reset cycle.
- Capture: on req_valid && req_ready, register addr/size/we/unsigned/wdata.
- Derived values: waddr = addr[ADDR_W-1:0] with bits[1:0] cleared; off = addr[1:0].
- Big-endian lanes:
  - byte off 0→[31:24], 1→[23:16], 2→[15:8], 3→[7:0]
  - half off 0→[31:16], off 2→[15:0]
- Error check happens at capture. Error → next state RESP, no memory traffic. Flags are not mutually exclusive.
- FSM states: IDLE, RD, WR, MERGE, RESP.
  - IDLE: req_ready=1; mem_we=0. On accept:
    - error → RESP
    - load → RD
    - word store → WR
    - sub-word store → RD
  - RD: mem_addr=waddr, mem_we=0. Next: MERGE for store, RESP for load.
  - MERGE: mem_addr=waddr, mem_we=1, mem_din = mem_dout with the selected lane replaced by wdata[7:0] or wdata[15:0] → RESP. mem_dout is stable here because RAM holds dout during writes.
  - WR: mem_addr=waddr, mem_we=1, mem_din=wdata → RESP.
  - RESP: resp_valid=1 for exactly one cycle → IDLE.
    - Loads: resp_rdata = lane extracted from mem_dout and extended per req_unsigned; word loads pass through.
    - resp_fault = mem_seg_faults[addr[10:8]] for completed memory accesses, else 0.
    - No response back-pressure: the consumer must accept the pulse.
- Latency (accept edge to resp_valid cycle): error 1; load 2; word store 2; sub-word store 3.
- Outside RD/WR/MERGE: mem_we=0, mem_addr and mem_din hold 0.
- Aligned words never cross a 256-byte chip boundary (max offset 252), so a correct RAM never raises a fault.
- A request offered outside IDLE is ignored; req_valid must be held until accepted.

Decomposition:
- Shared package lsu_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - state enum
  - ADDR_W constant
- One natural sub-module, lsu_lane_unit (combinational):
  - load extract/extend
  - store merge
  - misalign check
- FSM, capture registers and RAM drive stay in lsu_mem_master.

Test Plan:
- SW 0x11223344 @0x104, then LW @0x104 → mem_addr=0x104, mem_we pulses once, LW resp_rdata=0x11223344; latencies 2 and 2.
- After above, SB 0x80 @0x105, then:
  - LB @0x105 → 0xFFFFFF80
  - LBU @0x105 → 0x00000080
  - LW @0x104 → 0x11803344
  - SB latency 3, exactly one mem_we pulse, at mem_addr=0x104.
- SH 0xBEEF @0x106 → LW @0x104 = 0x1180BEEF; LH @0x106 → 0xFFFFBEEF; LHU @0x104 → 0x00001180.
- LW @0x105 → resp_valid 1 cycle after accept with resp_misaligned=1 and resp_rdata=0. SW @0x800 → resp_range_err=1 and mem_we never asserted. SH @0x103 → misaligned=1.
- Word store to byte 0x3FC of chip 3 → resp_fault=0. Force mem_seg_faults[3]=1 during RESP → resp_fault=1.
- Assert rst during the RD cycle of an SB → no mem_we pulse, resp_valid=0, state IDLE, req_ready=1 on the next cycle.
